// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned MAX_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First asserted bit searching rr_ptr+1, rr_ptr+2, ... modulo num_req.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]   valid,
        input logic [MAX_IDX_W-1:0] rr_ptr,
        input int unsigned          num_req
    );
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            cand = 32'(rr_ptr) + 32'd1 + k;
            if (cand >= num_req) cand = cand - num_req;
            if ((k < num_req) && !pick.found && valid[cand[MAX_IDX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[MAX_IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin select: rotate past the last owner, priority-encode,
// and map the winner back to an absolute requester index.
module rr_priority_select
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(valid_i), MAX_IDX_W'(rr_ptr_i), NUM_REQ);
        found_o = pick.found;
        idx_o   = IDX_W'(pick.idx);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ packet producers.
//
//   state | meaning
//   IDLE  | no owner; pick next requester after rr_ptr, no beat accepted
//   GRANT | grant_id owns the write port until last beat or MAX_BURST beats
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned MAX_BURST  = 8,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ),
    localparam int unsigned CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ-1:0]                  req_last,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                fifo_wr_en,
    output logic [DATA_WIDTH-1:0]               fifo_wr_data,
    input  logic                                fifo_full,
    output logic [IDX_W-1:0]                    grant_id,
    output logic                                busy
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] grant_id_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             busy_q;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             release_beat;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_sel (
        .valid_i  (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    // Handshake is combinational so fifo_full back-pressures in the same cycle.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = req_data[grant_id_q];
        if (!rst && (state_q == GRANT)) begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_en            = req_valid[grant_id_q] && !fifo_full;
        end
        release_beat = fifo_wr_en &&
                       (req_last[grant_id_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_id_q <= pick_idx;
                        state_q    <= GRANT;
                        busy_q     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (fifo_wr_en) begin
                        if (release_beat) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            rr_ptr_q   <= grant_id_q;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer beat queues drive the inputs and
// the expected FIFO write order is checked as each write strobe appears.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 16;
    localparam int MAX_BURST = 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0][DW-1:0]   req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         fifo_wr_en;
    logic [DW-1:0]                fifo_wr_data;
    logic                         fifo_full;
    logic [1:0]                   grant_id;
    logic                         busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [16:0] pq[NUM_REQ][$];
    int          hold[NUM_REQ];
    int          wr_cnt[NUM_REQ];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rst_cyc = -1;
    int          full_lo = 0;
    int          full_hi = 0;
    int          full_seen = 0;
    int          total_wr = 0;
    int          m_cnt = 0;
    bit          rst_req;
    bit          prev_rel;
    int          bubble_p = -1;
    logic [15:0] bubble_data = '0;
    int          bubble_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int p, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++)
            pq[p].push_back({(i == n - 1), base + 16'(i)});
    endtask

    task automatic expect_beats(input int p, input logic [15:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.id   = p;
            e.data = base + 16'(i);
            exp_q.push_back(e);
        end
    endtask

    function automatic bit all_empty();
        bit r;
        r = (exp_q.size() == 0);
        for (int p = 0; p < NUM_REQ; p++)
            if (pq[p].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic step();
        logic [16:0] h;
        logic [16:0] d;
        exp_t        e;
        bit          rel;
        @(posedge clk);
        #1;
        cyc++;
        rst       = rst_req || (cyc == rst_cyc);
        fifo_full = (cyc >= full_lo) && (cyc < full_hi);
        for (int p = 0; p < NUM_REQ; p++) begin
            h = (pq[p].size() != 0) ? pq[p][0] : 17'h0;
            req_data[p] = h[15:0];
            req_last[p] = h[16];
            if (hold[p] > 0) begin
                req_valid[p] = 1'b0;
                hold[p]--;
            end else begin
                req_valid[p] = (pq[p].size() != 0);
            end
        end
        @(negedge clk);
        chk("ready_onehot", 32'($onehot0(req_ready)), 1);
        if (rst) begin
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_wr_en", 32'(fifo_wr_en), 0);
            m_cnt    = 0;
            prev_rel = 1'b0;
        end else begin
            if (prev_rel) chk("idle_gap_busy", 32'(busy), 0);
            prev_rel = 1'b0;
            if (fifo_full) begin
                chk("full_wr_en", 32'(fifo_wr_en), 0);
                chk("full_ready", 32'(req_ready), 0);
                full_seen++;
            end
            chk("wr_en_vs_handshake", 32'(fifo_wr_en), 32'(|(req_valid & req_ready)));
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", 32'(fifo_wr_data), 32'(e.data));
                    chk("wr_grant_id", 32'(grant_id), 32'(e.id));
                    total_wr++;
                    wr_cnt[e.id]++;
                    rel = req_last[e.id] || (m_cnt == MAX_BURST - 1);
                    if (rel) begin
                        m_cnt    = 0;
                        prev_rel = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
        for (int p = 0; p < NUM_REQ; p++) begin
            if (req_valid[p] && req_ready[p] && (pq[p].size() != 0)) begin
                d = pq[p].pop_front();
                if ((p == bubble_p) && (d[15:0] == bubble_data)) hold[p] = bubble_len;
            end
        end
    endtask

    task automatic run(input int budget);
        int i;
        i = 0;
        while ((i < budget) && !all_empty()) begin
            step();
            i++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        rst       = 1'b1;
        rst_req   = 1'b1;
        prev_rel  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        for (int p = 0; p < NUM_REQ; p++) begin
            hold[p]   = 0;
            wr_cnt[p] = 0;
        end

        step();
        step();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_grant_id", 32'(grant_id), 0);
        rst_req = 1'b0;

        // Reset priority: requester 0 is next after rr_ptr=3, so 1 then 3.
        total_wr = 0;
        load(1, 16'h1111, 1);
        load(3, 16'h3333, 1);
        expect_beats(1, 16'h1111, 1);
        expect_beats(3, 16'h3333, 1);
        run(50);
        chk("s1_wr_pulses", 32'(total_wr), 2);

        // Round-robin fairness over 16 single-beat grants.
        for (int p = 0; p < NUM_REQ; p++) wr_cnt[p] = 0;
        for (int k = 0; k < 4; k++)
            for (int p = 0; p < NUM_REQ; p++) begin
                pq[p].push_back({1'b1, 16'(p * 256 + k)});
                expect_beats(p, 16'(p * 256 + k), 1);
            end
        run(200);
        for (int p = 0; p < NUM_REQ; p++) chk("rr_per_producer", 32'(wr_cnt[p]), 4);

        // Packet lock with a 2-cycle valid bubble after A0.
        bubble_p    = 2;
        bubble_data = 16'h00A0;
        bubble_len  = 2;
        load(2, 16'h00A0, 3);
        expect_beats(2, 16'h00A0, 3);
        expect_beats(0, 16'h00B0, 1);
        step();
        load(0, 16'h00B0, 1);
        run(60);
        bubble_p = -1;

        // MAX_BURST forced release and continuation.
        load(1, 16'h1001, 12);
        load(3, 16'h3001, 2);
        expect_beats(1, 16'h1001, 8);
        expect_beats(3, 16'h3001, 2);
        expect_beats(1, 16'h1009, 4);
        run(100);

        // FIFO full for 5 cycles inside a granted burst.
        full_seen = 0;
        full_lo   = cyc + 4;
        full_hi   = full_lo + 5;
        load(2, 16'h2001, 10);
        load(0, 16'h0C01, 2);
        expect_beats(2, 16'h2001, 8);
        expect_beats(0, 16'h0C01, 2);
        expect_beats(2, 16'h2009, 2);
        run(100);
        chk("full_cycles", 32'(full_seen), 5);

        // Reset during beat 3 of a 5-beat packet.
        load(1, 16'h5001, 5);
        expect_beats(1, 16'h5001, 2);
        step();
        step();
        step();
        rst_cyc = cyc + 1;
        load(0, 16'h00B1, 1);
        step();
        expect_beats(0, 16'h00B1, 1);
        expect_beats(1, 16'h5003, 3);
        step();
        chk("rst_mid_busy", 32'(busy), 0);
        run(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
